// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, data word, and arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned RETRY_MAX_DEF  = 3;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear priority; sat is high while the count equals MAX.
module arb_sat_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sat = (count_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data has priority, fetches are guaranteed a grant after
// STARVE_MAX consecutive data hits, and ERROR responses are retried up to RETRY_MAX.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned RETRY_MAX  = RETRY_MAX_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        fault
);

    arb_state_t state_q, state_d;
    logic       fault_q, fault_d;
    ramstate_t  rs;
    logic       d_pend;
    logic       starve_sat, starve_inc, starve_clr;
    logic       retry_sat, retry_inc, retry_clr;

    assign rs     = ramstate_t'(ramstate);
    assign d_pend = dREN | dWEN;

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        retry_inc = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;
        case (state_q)
            IDLE: begin
                if (d_pend && (!starve_sat || !iREN)) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (rs == ACCESS) begin
                        ihit    = 1'b1;
                        iload   = ramload;
                        state_d = IDLE;
                    end else if (rs == ERROR) begin
                        if (retry_sat) begin
                            fault_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            retry_inc = 1'b1;
                        end
                    end
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_pend) begin
                    state_d = IDLE;
                end else begin
                    // A simultaneous read and write request is serviced as a write.
                    ramWEN = dWEN;
                    ramREN = !dWEN;
                    if (rs == ACCESS) begin
                        dhit    = 1'b1;
                        dload   = dWEN ? '0 : ramload;
                        state_d = IDLE;
                    end else if (rs == ERROR) begin
                        if (retry_sat) begin
                            fault_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            retry_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

    // Retry budget is per grant, so it is dropped whenever the grant ends.
    assign retry_clr  = (state_q == IDLE) || ihit || dhit || (fault_d && !fault_q);
    assign starve_inc = dhit && iREN;
    assign starve_clr = ihit || !iREN;

    arb_sat_counter #(.MAX(STARVE_MAX)) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starve_sat)
    );

    arb_sat_counter #(.MAX(RETRY_MAX)) u_retry (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (retry_inc),
        .clr  (retry_clr),
        .sat  (retry_sat)
    );

endmodule
